// File: rtl/divisible_by_n_fsm_if.sv
// Serial-stream port bundle for the divisibility detector.
interface divisible_by_n_fsm_if #(
  parameter int unsigned DIV_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             clear;
  logic [DIV_W-1:0] div_sel;
  logic             out;
  logic [DIV_W-1:0] rem;
  logic [CNT_W-1:0] bit_cnt;
  logic             cnt_sat;
  logic             div_err;

  modport master (
    output bit_in, bit_valid, clear, div_sel,
    input  out, rem, bit_cnt, cnt_sat, div_err
  );

  modport slave (
    input  bit_in, bit_valid, clear, div_sel,
    output out, rem, bit_cnt, cnt_sat, div_err
  );
endinterface

// File: rtl/divisible_by_n_fsm.sv
// Tracks a serial bit stream modulo a run-time divisor and flags multiples.
// Moore machine: every output comes straight from a register.
module divisible_by_n_fsm #(
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned DEFAULT_DIV = 4,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input logic                 clk,
  input logic                 rst,
  divisible_by_n_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [DIV_W-1:0] rem_q, rem_n;
  logic [DIV_W-1:0] weight_q, weight_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             out_q, out_n;
  logic             sat_q, sat_n;
  logic             err_q, err_n;

  logic [DIV_W:0]   t_sum;
  logic [DIV_W:0]   u_dbl;
  logic [DIV_W:0]   d_ext;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= (DEFAULT_DIV == 0) ? ERR : IDLE;
      div_q    <= DIV_W'(DEFAULT_DIV);
      rem_q    <= '0;
      weight_q <= (DEFAULT_DIV == 1) ? '0 : DIV_W'(1);
      cnt_q    <= '0;
      out_q    <= 1'b0;
      sat_q    <= 1'b0;
      err_q    <= (DEFAULT_DIV == 0);
    end else begin
      state_q  <= state_n;
      div_q    <= div_n;
      rem_q    <= rem_n;
      weight_q <= weight_n;
      cnt_q    <= cnt_n;
      out_q    <= out_n;
      sat_q    <= sat_n;
      err_q    <= err_n;
    end
  end

  // Next-state: clear beats a valid bit; each bit costs one conditional subtract
  always_comb begin
    state_n  = state_q;
    div_n    = div_q;
    rem_n    = rem_q;
    weight_n = weight_q;
    cnt_n    = cnt_q;
    d_ext    = {1'b0, div_q};
    t_sum    = MSB_FIRST ? {rem_q, bus.bit_in}
                         : ({1'b0, rem_q} + (bus.bit_in ? {1'b0, weight_q} : '0));
    u_dbl    = {weight_q, 1'b0};

    if (bus.clear) begin
      div_n    = bus.div_sel;
      rem_n    = '0;
      weight_n = (bus.div_sel == DIV_W'(1)) ? '0 : DIV_W'(1);
      cnt_n    = '0;
      state_n  = (bus.div_sel == '0) ? ERR : IDLE;
    end else if (bus.bit_valid && (state_q != ERR)) begin
      rem_n = DIV_W'((t_sum >= d_ext) ? (t_sum - d_ext) : t_sum);
      if (!MSB_FIRST) begin
        weight_n = DIV_W'((u_dbl >= d_ext) ? (u_dbl - d_ext) : u_dbl);
      end
      if (cnt_q != CNT_MAX) begin
        cnt_n = cnt_q + CNT_W'(1);
      end
      state_n = RUN;
    end

    out_n = (state_n == RUN) && (rem_n == '0);
    sat_n = (cnt_n == CNT_MAX);
    err_n = (state_n == ERR);
  end

  assign bus.out     = out_q;
  assign bus.rem     = rem_q;
  assign bus.bit_cnt = cnt_q;
  assign bus.cnt_sat = sat_q;
  assign bus.div_err = err_q;

endmodule

// File: tb/tb_divisible_by_n_fsm.sv
// Bench for divisible_by_n_fsm: directed cases plus random stimulus vs an arithmetic model.
module tb_divisible_by_n_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_valid, clear;
  logic [3:0] div_sel;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Model: divisor, bits consumed since restart, value mod D for each bit order
  int unsigned m_d, m_k, m_ra, m_rb;
  bit          m_err;

  always #5 clk = ~clk;

  divisible_by_n_fsm_if #(.DIV_W(4), .CNT_W(4)) if_a ();
  divisible_by_n_fsm_if #(.DIV_W(4), .CNT_W(8)) if_b ();

  assign if_a.bit_in = bit_in;  assign if_a.bit_valid = bit_valid;
  assign if_a.clear  = clear;   assign if_a.div_sel   = div_sel;
  assign if_b.bit_in = bit_in;  assign if_b.bit_valid = bit_valid;
  assign if_b.clear  = clear;   assign if_b.div_sel   = div_sel;

  divisible_by_n_fsm #(.DIV_W(4), .DEFAULT_DIV(4), .MSB_FIRST(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));

  divisible_by_n_fsm #(.DIV_W(4), .DEFAULT_DIV(4), .MSB_FIRST(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned pow2_mod(input int unsigned k, input int unsigned d);
    int unsigned r = 1 % d;
    for (int i = 0; i < int'(k); i++) r = (r * 2) % d;
    return r;
  endfunction

  task automatic model_update(input bit r, input bit c, input int unsigned ds, input bit v, input bit b);
    if (r) begin
      m_d = 4; m_k = 0; m_ra = 0; m_rb = 0; m_err = 1'b0;
    end else if (c) begin
      m_d = ds; m_k = 0; m_ra = 0; m_rb = 0; m_err = (ds == 0);
    end else if (v && !m_err) begin
      m_ra = (m_ra * 2 + int'(b)) % m_d;
      m_rb = (m_rb + (b ? pow2_mod(m_k, m_d) : 0)) % m_d;
      m_k++;
    end
  endtask

  task automatic check_all();
    chk("a_out", if_a.out,     (!m_err && m_k > 0 && m_ra == 0) ? 1 : 0);
    chk("a_rem", if_a.rem,     m_ra);
    chk("a_cnt", if_a.bit_cnt, (m_k > 15) ? 15 : m_k);
    chk("a_sat", if_a.cnt_sat, (m_k >= 15) ? 1 : 0);
    chk("a_err", if_a.div_err, m_err);
    chk("b_out", if_b.out,     (!m_err && m_k > 0 && m_rb == 0) ? 1 : 0);
    chk("b_rem", if_b.rem,     m_rb);
    chk("b_cnt", if_b.bit_cnt, (m_k > 255) ? 255 : m_k);
    chk("b_sat", if_b.cnt_sat, (m_k >= 255) ? 1 : 0);
    chk("b_err", if_b.div_err, m_err);
  endtask

  task automatic step(input bit r, input bit c, input logic [3:0] ds, input bit v, input bit b);
    rst = r; clear = c; div_sel = ds; bit_valid = v; bit_in = b;
    @(posedge clk);
    model_update(r, c, int'(ds), v, b);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int t1_bits [8] = '{0, 1, 0, 0, 0, 1, 0, 1};
    int t1_out  [8] = '{1, 0, 0, 1, 1, 0, 0, 0};
    int t1_rem  [8] = '{0, 1, 2, 0, 0, 1, 2, 1};
    int t2_bits [3] = '{1, 1, 0};
    int t2_rem  [3] = '{1, 0, 0};
    int t3_bits [4] = '{0, 1, 0, 1};
    int t3_rem  [4] = '{0, 2, 2, 0};

    rst = 1'b1; clear = 1'b0; div_sel = 4'd0; bit_valid = 1'b0; bit_in = 1'b0;
    m_d = 4; m_k = 0; m_ra = 0; m_rb = 0; m_err = 1'b0;

    // Reset state
    step(1, 0, 0, 0, 0);
    chk("rst_out", if_a.out, 0);
    chk("rst_cnt", if_a.bit_cnt, 0);

    // Default divisor 4, MSB-first
    foreach (t1_bits[i]) begin
      step(0, 0, 0, 1, t1_bits[i][0]);
      chk("t1_out", if_a.out, t1_out[i]);
      chk("t1_rem", if_a.rem, t1_rem[i]);
    end

    // Divisor 3, MSB-first
    step(0, 1, 4'd3, 0, 0);
    foreach (t2_bits[i]) begin
      step(0, 0, 0, 1, t2_bits[i][0]);
      chk("t2_rem", if_a.rem, t2_rem[i]);
    end
    chk("t2_cnt", if_a.bit_cnt, 3);

    // Divisor 5, LSB-first: value 10
    step(0, 1, 4'd5, 0, 0);
    foreach (t3_bits[i]) begin
      step(0, 0, 0, 1, t3_bits[i][0]);
      chk("t3_rem", if_b.rem, t3_rem[i]);
    end
    chk("t3_out", if_b.out, 1);

    // Zero divisor ignores the stream
    step(0, 1, 4'd0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);
    chk("t4_err", if_a.div_err, 1);
    chk("t4_cnt", if_a.bit_cnt, 0);
    step(0, 1, 4'd2, 0, 0);
    chk("t4_clr", if_a.div_err, 0);

    // Clear discards a coincident bit; reset mid-stream
    step(0, 0, 0, 1, 1);
    step(0, 1, 4'd7, 1, 1);
    chk("t5_cnt", if_a.bit_cnt, 0);
    chk("t5_out", if_a.out, 0);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    chk("t5_rst", if_b.bit_cnt, 0);

    // Saturation with divisor 2 on the 4-bit counter
    step(0, 1, 4'd2, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
    chk("t6_cnt", if_a.bit_cnt, 15);
    chk("t6_sat", if_a.cnt_sat, 1);
    chk("t6_out", if_a.out, 1);
    step(0, 0, 0, 1, 1);
    chk("t6_rem", if_a.rem, 1);
    chk("t6_out1", if_a.out, 0);
    chk("t6_cnt1", if_a.bit_cnt, 15);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, c, v, b;
      logic [3:0] ds;
      r  = ($urandom_range(0, 299) == 0);
      c  = ($urandom_range(0, 39) == 0);
      ds = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      v  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom);
      step(r, c, ds, v, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
